// File: rtl/park_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | park_pkg                                                             |
// | Shared widths, spot type and FSM state encoding for the parking lot. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package park_pkg;

  localparam int SPOT_W    = 3;
  localparam int NUM_SPOTS = 8;

  typedef logic [SPOT_W-1:0] spot_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALLOC = 2'd1,
    ISSUE = 2'd2
  } park_state_t;

  function automatic logic [SPOT_W:0] count_free(input logic [NUM_SPOTS-1:0] occ);
    logic [SPOT_W:0] n;
    n = (SPOT_W+1)'(NUM_SPOTS);
    for (int i = 0; i < NUM_SPOTS; i++) begin
      n = n - {{SPOT_W{1'b0}}, occ[i]};
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/park_free_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | park_free_encoder                                                    |
// | Combinational lowest-free-spot finder over the occupancy vector.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module park_free_encoder
  import park_pkg::*;
(
  input  logic [NUM_SPOTS-1:0] i_occupancy,
  output spot_t                o_free_idx,
  output logic                 o_any_free
);

  // Scan from the top down so the last hit wins and yields the lowest index.
  always_comb begin
    o_free_idx = '0;
    for (int i = NUM_SPOTS - 1; i >= 0; i--) begin
      if (!i_occupancy[i]) begin
        o_free_idx = spot_t'(i);
      end
    end
  end

  assign o_any_free = ~&i_occupancy;

endmodule
`default_nettype wire

// File: rtl/park_entry_allocator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | park_entry_allocator                                                 |
// | Entry stage: allocates the lowest free spot, issues spot^pattern     |
// | tokens, frees spots on exit. Optional stats via PARK_STATS_EN.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module park_entry_allocator
  import park_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              enter,
  input  spot_t             pattern,
  input  logic              token_ack,
  input  logic              exit_valid,
  input  spot_t             exit_park_number,
  output spot_t             token,
  output logic              token_valid,
  output logic              reject,
  output logic              exit_error,
  output logic              full,
  output logic [SPOT_W:0]   free_count
`ifdef PARK_STATS_EN
  ,
  output logic [7:0]        entry_count,
  output logic [7:0]        reject_count
`endif
);

  park_state_t          r_state;
  park_state_t          w_state_next;
  logic [NUM_SPOTS-1:0] r_occ;
  logic [NUM_SPOTS-1:0] w_set;
  logic [NUM_SPOTS-1:0] w_clr;
  spot_t                r_pattern;
  spot_t                r_token;
  spot_t                w_free_idx;
  logic                 w_any_free;
  logic                 w_latch;
  logic                 w_alloc;
  logic                 w_reject;
  logic                 w_exit_err;
  logic                 r_reject;
  logic                 r_exit_error;
  logic [SPOT_W:0]      w_free_count;
  logic                 w_full;

  park_free_encoder u_free_enc (
    .i_occupancy (r_occ),
    .o_free_idx  (w_free_idx),
    .o_any_free  (w_any_free)
  );

  assign w_free_count = count_free(r_occ);
  assign w_full       = (w_free_count == '0);

  always_comb begin
    w_state_next = r_state;
    w_latch      = 1'b0;
    w_alloc      = 1'b0;
    w_reject     = 1'b0;
    case (r_state)
      IDLE: begin
        if (enter) begin
          if (w_full) begin
            w_reject = 1'b1;
          end else begin
            w_latch      = 1'b1;
            w_state_next = ALLOC;
          end
        end
      end
      ALLOC: begin
        // Only exits can occur since IDLE saw a free spot, so one is always left.
        w_alloc      = w_any_free;
        w_state_next = w_any_free ? ISSUE : IDLE;
      end
      ISSUE: begin
        if (token_ack) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Set targets a free bit, clear an occupied one, so they never collide.
  assign w_set      = w_alloc ? (NUM_SPOTS'(1) << w_free_idx) : '0;
  assign w_clr      = (exit_valid && r_occ[exit_park_number])
                      ? (NUM_SPOTS'(1) << exit_park_number) : '0;
  assign w_exit_err = exit_valid && !r_occ[exit_park_number];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_occ        <= '0;
      r_pattern    <= '0;
      r_token      <= '0;
      r_reject     <= 1'b0;
      r_exit_error <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_occ        <= (r_occ | w_set) & ~w_clr;
      r_reject     <= w_reject;
      r_exit_error <= w_exit_err;
      if (w_latch) begin
        r_pattern <= pattern;
      end
      if (w_alloc) begin
        r_token <= w_free_idx ^ r_pattern;
      end
    end
  end

  assign token       = r_token;
  assign token_valid = (r_state == ISSUE);
  assign reject      = r_reject;
  assign exit_error  = r_exit_error;
  assign full        = w_full;
  assign free_count  = w_free_count;

`ifdef PARK_STATS_EN
  logic [7:0] r_entry_cnt;
  logic [7:0] r_reject_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_entry_cnt  <= '0;
      r_reject_cnt <= '0;
    end else begin
      if (w_alloc && (r_entry_cnt != 8'hFF)) begin
        r_entry_cnt <= r_entry_cnt + 8'd1;
      end
      if (w_reject && (r_reject_cnt != 8'hFF)) begin
        r_reject_cnt <= r_reject_cnt + 8'd1;
      end
    end
  end

  assign entry_count  = r_entry_cnt;
  assign reject_count = r_reject_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_park_entry_allocator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_park_entry_allocator                                              |
// | Directed self-checking bench for park_entry_allocator.               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_park_entry_allocator;

  logic       clk = 1'b0;
  logic       reset;
  logic       enter;
  logic [2:0] pattern;
  logic       token_ack;
  logic       exit_valid;
  logic [2:0] exit_park_number;
  logic [2:0] token;
  logic       token_valid;
  logic       reject;
  logic       exit_error;
  logic       full;
  logic [3:0] free_count;
`ifdef PARK_STATS_EN
  logic [7:0] entry_count;
  logic [7:0] reject_count;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  park_entry_allocator dut (
    .clk              (clk),
    .reset            (reset),
    .enter            (enter),
    .pattern          (pattern),
    .token_ack        (token_ack),
    .exit_valid       (exit_valid),
    .exit_park_number (exit_park_number),
    .token            (token),
    .token_valid      (token_valid),
    .reject           (reject),
    .exit_error       (exit_error),
    .full             (full),
    .free_count       (free_count)
`ifdef PARK_STATS_EN
    ,
    .entry_count      (entry_count),
    .reject_count     (reject_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1; enter = 1'b0; pattern = '0; token_ack = 1'b0;
    exit_valid = 1'b0; exit_park_number = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic do_entry(input logic [2:0] pat, input logic [2:0] exp_tok, input string name);
    enter = 1'b1; pattern = pat;
    tick();
    enter = 1'b0;
    tick();
    tests++;
    if ({token_valid, token} !== {1'b1, exp_tok}) begin
      fails++;
      $display("FAIL %s: valid/token=%b/%b expected 1/%b", name, token_valid, token, exp_tok);
    end
    token_ack = 1'b1;
    tick();
    token_ack = 1'b0;
  endtask

  task automatic do_exit(input logic [2:0] spot);
    exit_valid = 1'b1; exit_park_number = spot;
    tick();
    exit_valid = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    tests++;
    if ({token_valid, token, reject, exit_error, full, free_count} !== {1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 4'd8}) begin
      fails++;
      $display("FAIL reset_state: v=%b tok=%b rej=%b err=%b full=%b free=%0d expected 0/000/0/0/0/8",
               token_valid, token, reject, exit_error, full, free_count);
    end
`ifdef PARK_STATS_EN
    tests++;
    if ({entry_count, reject_count} !== 16'h0000) begin
      fails++;
      $display("FAIL reset_stats: entry=%0d reject=%0d expected 0/0", entry_count, reject_count);
    end
`endif
  endtask

  task automatic test_first_entry();
    apply_reset();
    enter = 1'b1; pattern = 3'b101;
    tick();
    enter = 1'b0;
    tests++;
    if ({token_valid, free_count} !== {1'b0, 4'd8}) begin
      fails++;
      $display("FAIL first_alloc_cycle: valid=%b free=%0d expected 0/8", token_valid, free_count);
    end
    tick();
    tests++;
    if ({token_valid, token, free_count} !== {1'b1, 3'b101, 4'd7}) begin
      fails++;
      $display("FAIL first_issue: valid=%b tok=%b free=%0d expected 1/101/7", token_valid, token, free_count);
    end
    tick();
    tests++;
    if ({token_valid, token} !== {1'b1, 3'b101}) begin
      fails++;
      $display("FAIL first_hold: valid=%b tok=%b expected 1/101", token_valid, token);
    end
    token_ack = 1'b1;
    tick();
    token_ack = 1'b0;
    tests++;
    if ({token_valid, free_count} !== {1'b0, 4'd7}) begin
      fails++;
      $display("FAIL first_acked: valid=%b free=%0d expected 0/7", token_valid, free_count);
    end
  endtask

  task automatic test_fill_and_reject();
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      do_entry(3'b000, 3'(i), $sformatf("fill_tok%0d", i));
    end
    tests++;
    if ({full, free_count} !== {1'b1, 4'd0}) begin
      fails++;
      $display("FAIL fill_full: full=%b free=%0d expected 1/0", full, free_count);
    end
    enter = 1'b1;
    tick();
    enter = 1'b0;
    tests++;
    if ({reject, token_valid} !== 2'b10) begin
      fails++;
      $display("FAIL reject_pulse: rej=%b valid=%b expected 1/0", reject, token_valid);
    end
    tick();
    tests++;
    if ({reject, token_valid, full, free_count} !== {1'b0, 1'b0, 1'b1, 4'd0}) begin
      fails++;
      $display("FAIL reject_after: rej=%b valid=%b full=%b free=%0d expected 0/0/1/0",
               reject, token_valid, full, free_count);
    end
`ifdef PARK_STATS_EN
    tests++;
    if ({entry_count, reject_count} !== {8'd8, 8'd1}) begin
      fails++;
      $display("FAIL stats_counts: entry=%0d reject=%0d expected 8/1", entry_count, reject_count);
    end
`endif
  endtask

  task automatic test_exit_reenter();
    do_exit(3'd3);
    tests++;
    if ({free_count, full, exit_error} !== {4'd1, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL exit3: free=%0d full=%b err=%b expected 1/0/0", free_count, full, exit_error);
    end
    do_entry(3'b101, 3'b110, "reenter_tok");
    tests++;
    if ({free_count, full} !== {4'd0, 1'b1}) begin
      fails++;
      $display("FAIL reenter_full: free=%0d full=%b expected 0/1", free_count, full);
    end
  endtask

  task automatic test_exit_error();
    do_exit(3'd5);
    tests++;
    if ({exit_error, free_count} !== {1'b0, 4'd1}) begin
      fails++;
      $display("FAIL exit5_first: err=%b free=%0d expected 0/1", exit_error, free_count);
    end
    do_exit(3'd5);
    tests++;
    if ({exit_error, free_count} !== {1'b1, 4'd1}) begin
      fails++;
      $display("FAIL exit5_error: err=%b free=%0d expected 1/1", exit_error, free_count);
    end
    tick();
    tests++;
    if (exit_error !== 1'b0) begin
      fails++;
      $display("FAIL exit_error_pulse: err=%b expected 0", exit_error);
    end
  endtask

  task automatic test_exit_during_alloc();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      do_entry(3'b000, 3'(i), $sformatf("pre_tok%0d", i));
    end
    enter = 1'b1; pattern = 3'b000;
    tick();
    enter = 1'b0;
    exit_valid = 1'b1; exit_park_number = 3'd0;
    tick();
    exit_valid = 1'b0;
    tests++;
    if ({token_valid, token, free_count, exit_error} !== {1'b1, 3'd3, 4'd5, 1'b0}) begin
      fails++;
      $display("FAIL exit_alloc: valid=%b tok=%0d free=%0d err=%b expected 1/3/5/0",
               token_valid, token, free_count, exit_error);
    end
    do_exit(3'd3);
    tests++;
    if ({token_valid, token, free_count} !== {1'b1, 3'd3, 4'd6}) begin
      fails++;
      $display("FAIL exit_in_issue: valid=%b tok=%0d free=%0d expected 1/3/6", token_valid, token, free_count);
    end
    token_ack = 1'b1;
    tick();
    token_ack = 1'b0;
    do_entry(3'b000, 3'd0, "realloc_spot0");
  endtask

  task automatic test_ack_outside_issue();
    token_ack = 1'b1;
    tick();
    tests++;
    if ({token_valid, free_count} !== {1'b0, 4'd5}) begin
      fails++;
      $display("FAIL ack_idle: valid=%b free=%0d expected 0/5", token_valid, free_count);
    end
    enter = 1'b1; pattern = 3'b010;
    tick();
    enter = 1'b0;
    tick();
    tests++;
    if ({token_valid, token} !== {1'b1, 3'b001}) begin
      fails++;
      $display("FAIL ack_held_issue: valid=%b tok=%b expected 1/001", token_valid, token);
    end
    tick();
    token_ack = 1'b0;
    tests++;
    if ({token_valid, free_count} !== {1'b0, 4'd4}) begin
      fails++;
      $display("FAIL ack_held_return: valid=%b free=%0d expected 0/4", token_valid, free_count);
    end
  endtask

  task automatic test_reset_in_issue();
    enter = 1'b1; pattern = 3'b000;
    tick();
    enter = 1'b0;
    tick();
    tests++;
    if ({token_valid, token} !== {1'b1, 3'd4}) begin
      fails++;
      $display("FAIL pre_reset_issue: valid=%b tok=%0d expected 1/4", token_valid, token);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++;
    if ({token_valid, token, full, free_count} !== {1'b0, 3'd0, 1'b0, 4'd8}) begin
      fails++;
      $display("FAIL reset_in_issue: valid=%b tok=%0d full=%b free=%0d expected 0/0/0/8",
               token_valid, token, full, free_count);
    end
`ifdef PARK_STATS_EN
    tests++;
    if ({entry_count, reject_count} !== 16'h0000) begin
      fails++;
      $display("FAIL reset_in_issue_stats: entry=%0d reject=%0d expected 0/0", entry_count, reject_count);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; enter = 1'b0; pattern = '0; token_ack = 1'b0;
    exit_valid = 1'b0; exit_park_number = '0;
    @(negedge clk);
    test_reset();
    test_first_entry();
    test_fill_and_reject();
    test_exit_reenter();
    test_exit_error();
    test_exit_during_alloc();
    test_ack_outside_issue();
    test_reset_in_issue();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
